// File: rtl/ov5640_dvp_pattern_gen.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_pattern_gen
//
// Emulates the DVP output of an OV5640 camera: a frame is a VSYNC pulse,
// a vertical back porch, cfg_height lines of cfg_width active bytes (HREF
// high) separated by horizontal blanking, and a vertical front porch.
// The byte stream carries one of four test patterns.
//
// Ports
//   CCD_PCLK     in   pixel clock, rising edge
//   CCD_RSTN     in   asynchronous active-low reset
//   enable       in   frames are generated while high (a running frame
//                     always completes)
//   cfg_width    in   active bytes per line (sampled at frame start)
//   cfg_height   in   active lines per frame (sampled at frame start)
//   pattern_sel  in   0: byte index, 1: line index, 2: running byte count,
//                     3: byte ^ line ^ frame count
//   CCD_VSYNC    out  vertical sync pulse
//   CCD_HSYNC    out  HREF, high while active bytes are driven
//   CCD_DATA     out  pixel byte, 0 outside HREF
//   busy         out  high whenever the generator is not idle
//   frame_cnt    out  number of completed frames (wraps)
//
// All outputs are registered from the next-state values, so each output
// reflects the FSM state held in the same cycle.
// ---------------------------------------------------------------------------
module ov5640_dvp_pattern_gen #(
    parameter int VSYNC_CYCLES  = 16,
    parameter int VBP_CYCLES    = 32,
    parameter int HBLANK_CYCLES = 8,
    parameter int VFP_CYCLES    = 32
) (
    input  logic        CCD_PCLK,
    input  logic        CCD_RSTN,
    input  logic        enable,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic [1:0]  pattern_sel,
    output logic        CCD_VSYNC,
    output logic        CCD_HSYNC,
    output logic [7:0]  CCD_DATA,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_CYCLES - 1);
    localparam logic [15:0] VBP_LAST    = 16'(VBP_CYCLES - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(HBLANK_CYCLES - 1);
    localparam logic [15:0] VFP_LAST    = 16'(VFP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFP    = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;          // cycles spent in the current timed phase
    logic [15:0] h_r, h_s;              // byte index within the line
    logic [15:0] v_r, v_s;              // line index within the frame
    logic [7:0]  byte_r, byte_s;        // running byte counter (pattern 2)
    logic [15:0] width_r, width_s;
    logic [15:0] height_r, height_s;
    logic [1:0]  sel_r, sel_s;
    logic [15:0] frame_cnt_s;
    logic [7:0]  data_s;
    logic        cfg_ok_s;
    logic        frame_start_s;

    assign cfg_ok_s = (cfg_width != 16'd0) && (cfg_height != 16'd0);

    // Next-state logic of the frame timing FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && cfg_ok_s) state_s = ST_VSYNC;
                else                    state_s = ST_IDLE;
            end
            ST_VSYNC: begin
                if (cnt_r == VSYNC_LAST) state_s = ST_VBP;
                else                     state_s = ST_VSYNC;
            end
            ST_VBP: begin
                if (cnt_r == VBP_LAST) state_s = ST_ACTIVE;
                else                   state_s = ST_VBP;
            end
            ST_ACTIVE: begin
                if (h_r == width_r - 16'd1) begin
                    if (v_r == height_r - 16'd1) state_s = ST_VFP;
                    else                         state_s = ST_HBLANK;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_HBLANK: begin
                if (cnt_r == HBLANK_LAST) state_s = ST_ACTIVE;
                else                      state_s = ST_HBLANK;
            end
            ST_VFP: begin
                if (cnt_r == VFP_LAST) begin
                    if (enable && cfg_ok_s) state_s = ST_VSYNC;
                    else                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_VFP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of counters, latched configuration and output data.
    always_comb begin
        frame_start_s = (state_s == ST_VSYNC) && (state_r != ST_VSYNC);

        // Phase counter restarts on every state change; idle and active
        // lines do not use it.
        if ((state_s == state_r) && (state_r != ST_IDLE) && (state_r != ST_ACTIVE)) begin
            cnt_s = cnt_r + 16'd1;
        end else begin
            cnt_s = 16'd0;
        end

        if (frame_start_s) begin
            width_s  = cfg_width;
            height_s = cfg_height;
            sel_s    = pattern_sel;
        end else begin
            width_s  = width_r;
            height_s = height_r;
            sel_s    = sel_r;
        end

        if ((state_s == ST_ACTIVE) && (state_r == ST_ACTIVE)) begin
            h_s = h_r + 16'd1;
        end else begin
            h_s = 16'd0;
        end

        if (frame_start_s) begin
            v_s = 16'd0;
        end else if ((state_r == ST_HBLANK) && (state_s == ST_ACTIVE)) begin
            v_s = v_r + 16'd1;
        end else if ((state_r == ST_VBP) && (state_s == ST_ACTIVE)) begin
            v_s = 16'd0;
        end else begin
            v_s = v_r;
        end

        // byte_r holds the value shown on the current active byte, so it
        // advances after every active cycle and is held through blanking.
        if (frame_start_s) begin
            byte_s = 8'd0;
        end else if (state_r == ST_ACTIVE) begin
            byte_s = byte_r + 8'd1;
        end else begin
            byte_s = byte_r;
        end

        if ((state_r == ST_VFP) && (cnt_r == VFP_LAST)) begin
            frame_cnt_s = frame_cnt + 16'd1;
        end else begin
            frame_cnt_s = frame_cnt;
        end

        data_s = 8'd0;
        if (state_s == ST_ACTIVE) begin
            case (sel_s)
                2'd0:    data_s = h_s[7:0];
                2'd1:    data_s = v_s[7:0];
                2'd2:    data_s = byte_s;
                2'd3:    data_s = h_s[7:0] ^ v_s[7:0] ^ frame_cnt_s[7:0];
                default: data_s = 8'd0;
            endcase
        end else begin
            data_s = 8'd0;
        end
    end

    // State, counter and registered output update.
    always_ff @(posedge CCD_PCLK or negedge CCD_RSTN) begin
        if (!CCD_RSTN) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            h_r       <= 16'd0;
            v_r       <= 16'd0;
            byte_r    <= 8'd0;
            width_r   <= 16'd0;
            height_r  <= 16'd0;
            sel_r     <= 2'd0;
            frame_cnt <= 16'd0;
            CCD_VSYNC <= 1'b0;
            CCD_HSYNC <= 1'b0;
            CCD_DATA  <= 8'd0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            h_r       <= h_s;
            v_r       <= v_s;
            byte_r    <= byte_s;
            width_r   <= width_s;
            height_r  <= height_s;
            sel_r     <= sel_s;
            frame_cnt <= frame_cnt_s;
            CCD_VSYNC <= (state_s == ST_VSYNC);
            CCD_HSYNC <= (state_s == ST_ACTIVE);
            CCD_DATA  <= data_s;
            busy      <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ov5640_dvp_pattern_gen.sv
// ---------------------------------------------------------------------------
// Directed testbench for ov5640_dvp_pattern_gen with 2/2/2/2 timing.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ov5640_dvp_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] cfg_width = 16'd0;
    logic [15:0] cfg_height = 16'd0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        vsync, hsync, busy;
    logic [7:0]  data;
    logic [15:0] frame_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int both_hi_cnt = 0;
    int data_leak_cnt = 0;
    logic [7:0] got[$];

    ov5640_dvp_pattern_gen #(
        .VSYNC_CYCLES(2), .VBP_CYCLES(2), .HBLANK_CYCLES(2), .VFP_CYCLES(2)
    ) dut (
        .CCD_PCLK(clk), .CCD_RSTN(rst_n), .enable(enable),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .pattern_sel(pattern_sel),
        .CCD_VSYNC(vsync), .CCD_HSYNC(hsync), .CCD_DATA(data),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Continuous invariants: syncs exclusive, data zero outside HREF.
    always @(negedge clk) begin
        if (vsync && hsync) both_hi_cnt++;
        if (!hsync && data != 8'h00) data_leak_cnt++;
    end

    task automatic do_reset();
        enable = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic collect(input int n, input int budget, input string name);
        got.delete();
        for (int c = 0; c < budget && got.size() < n; c++) begin
            @(negedge clk);
            if (hsync) got.push_back(data);
        end
        tests_run++;
        if (got.size() != n) begin
            tests_failed++;
            $display("FAIL %s timeout: got %0d bytes, expected %0d", name, got.size(), n);
        end
    endtask

    task automatic wait_hsync(input int budget, input string name);
        int c;
        c = 0;
        while (!hsync && c < budget) begin
            @(negedge clk);
            c++;
        end
        tests_run++;
        if (!hsync) begin
            tests_failed++;
            $display("FAIL %s: hsync timeout, got 0 expected 1", name);
        end
    endtask

    // Counts HSYNC falls and bad-length lines until the next VSYNC rise.
    task automatic measure_frame(input int run0, output int lines, output int bad);
        logic prev_h, prev_v;
        int run;
        bit done;
        prev_h = hsync; prev_v = vsync; run = run0;
        lines = 0; bad = 0; done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (hsync) run++;
            else if (prev_h) begin
                lines++;
                if (run != 4) bad++;
                run = 0;
            end
            if (vsync && !prev_v) done = 1;
            prev_h = hsync; prev_v = vsync;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL measure_frame: vsync timeout, got none expected rise");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({vsync, hsync, data, busy, frame_cnt} !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected 0", {vsync, hsync, data, busy, frame_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        // bit9 = VSYNC, bit8 = HSYNC, bits7:0 = DATA
        logic [9:0] exp_tab [17] = '{
            10'h200, 10'h200, 10'h000, 10'h000,
            10'h100, 10'h101, 10'h102, 10'h103, 10'h000, 10'h000,
            10'h100, 10'h101, 10'h102, 10'h103, 10'h000, 10'h000,
            10'h200};
        do_reset();
        cfg_width = 16'd4; cfg_height = 16'd2; pattern_sel = 2'd0;
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            tests_run++;
            if ({vsync, hsync, data} !== exp_tab[i] || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_frame[%0d]: got %h busy %b expected %h busy 1",
                         i, {vsync, hsync, data}, busy, exp_tab[i]);
            end
            if (i == 15 || i == 16) begin
                tests_run++;
                if (frame_cnt !== ((i == 16) ? 16'd1 : 16'd0)) begin
                    tests_failed++;
                    $display("FAIL basic_frame_cnt[%0d]: got %0d expected %0d",
                             i, frame_cnt, (i == 16) ? 1 : 0);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_running_counter();
        logic [7:0] e;
        int errs;
        do_reset();
        cfg_width = 16'd200; cfg_height = 16'd2; pattern_sel = 2'd2;
        enable = 1'b1;
        collect(401, 1200, "running_counter");
        errs = 0;
        for (int i = 0; i < got.size(); i++) begin
            e = (i < 400) ? 8'(i) : 8'h00;
            tests_run++;
            if (got[i] !== e) begin
                tests_failed++;
                errs++;
                if (errs < 5) $display("FAIL running_counter[%0d]: got %h expected %h", i, got[i], e);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_line_and_xor_patterns();
        logic [7:0] exp1 [9] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02};
        logic [7:0] exp3 [8] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
        do_reset();
        cfg_width = 16'd3; cfg_height = 16'd3; pattern_sel = 2'd1;
        enable = 1'b1;
        collect(9, 200, "line_pattern");
        for (int i = 0; i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== exp1[i]) begin
                tests_failed++;
                $display("FAIL line_pattern[%0d]: got %h expected %h", i, got[i], exp1[i]);
            end
        end
        do_reset();
        cfg_width = 16'd2; cfg_height = 16'd2; pattern_sel = 2'd3;
        enable = 1'b1;
        collect(8, 200, "xor_pattern");
        for (int i = 0; i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== exp3[i]) begin
                tests_failed++;
                $display("FAIL xor_pattern[%0d]: got %h expected %h", i, got[i], exp3[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic prev;
        int falls, vs_seen;
        do_reset();
        cfg_width = 16'd4; cfg_height = 16'd2; pattern_sel = 2'd0;
        enable = 1'b1;
        wait_hsync(50, "enable_drop");
        @(negedge clk);
        tests_run++;
        if (data !== 8'h01) begin
            tests_failed++;
            $display("FAIL enable_drop_byte1: got %h expected 01", data);
        end
        enable = 1'b0;
        prev = hsync; falls = 0;
        for (int c = 0; c < 200 && busy; c++) begin
            @(negedge clk);
            if (prev && !hsync) falls++;
            prev = hsync;
        end
        tests_run++;
        if (falls != 2 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL enable_drop: got lines %0d busy %b frames %0d expected lines 2 busy 0 frames 1",
                     falls, busy, frame_cnt);
        end
        vs_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (vsync || busy) vs_seen++;
        end
        tests_run++;
        if (vs_seen != 0) begin
            tests_failed++;
            $display("FAIL enable_drop_idle: got %0d active cycles expected 0", vs_seen);
        end
    endtask

    task automatic test_cfg_zero();
        int act;
        do_reset();
        cfg_width = 16'd0; cfg_height = 16'd2; enable = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (vsync || busy || hsync) act++;
        end
        cfg_width = 16'd4; cfg_height = 16'd0;
        repeat (20) begin
            @(negedge clk);
            if (vsync || busy || hsync) act++;
        end
        tests_run++;
        if (act != 0) begin
            tests_failed++;
            $display("FAIL cfg_zero: got %0d active cycles expected 0", act);
        end
        enable = 1'b0;
    endtask

    task automatic test_height_change();
        int lines, bad;
        do_reset();
        cfg_width = 16'd4; cfg_height = 16'd3; pattern_sel = 2'd0;
        enable = 1'b1;
        wait_hsync(50, "height_change");
        cfg_height = 16'd5;
        measure_frame(1, lines, bad);
        tests_run++;
        if (lines != 3 || bad != 0) begin
            tests_failed++;
            $display("FAIL height_change_cur: got lines %0d bad %0d expected lines 3 bad 0", lines, bad);
        end
        measure_frame(0, lines, bad);
        tests_run++;
        if (lines != 5 || bad != 0) begin
            tests_failed++;
            $display("FAIL height_change_next: got lines %0d bad %0d expected lines 5 bad 0", lines, bad);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_active();
        logic [1:0] exp_v [3] = '{2'b10, 2'b10, 2'b00};
        int c;
        do_reset();
        cfg_width = 16'd4; cfg_height = 16'd2; pattern_sel = 2'd0;
        enable = 1'b1;
        c = 0;
        while (!(hsync && frame_cnt == 16'd1) && c < 200) begin
            @(negedge clk);
            c++;
        end
        tests_run++;
        if (!(hsync && frame_cnt == 16'd1)) begin
            tests_failed++;
            $display("FAIL reset_mid_active_setup: got hsync %b frames %0d expected 1 and 1", hsync, frame_cnt);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({vsync, hsync, data, busy, frame_cnt} !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_active: got %h expected 0", {vsync, hsync, data, busy, frame_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({vsync, hsync} !== exp_v[i] || frame_cnt !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_restart[%0d]: got vs/hs %b frames %0d expected %b frames 0",
                         i, {vsync, hsync}, frame_cnt, exp_v[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_invariants();
        tests_run++;
        if (both_hi_cnt != 0 || data_leak_cnt != 0) begin
            tests_failed++;
            $display("FAIL invariants: got overlap %0d leak %0d expected 0 and 0", both_hi_cnt, data_leak_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_running_counter();
        test_line_and_xor_patterns();
        test_enable_drop();
        test_cfg_zero();
        test_height_change();
        test_reset_mid_active();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
